// File: rtl/switch_pkg.sv
// Shared types and helpers for the two-port merge switch.
package switch_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef struct packed {
        logic [DEFAULT_ADDR_WIDTH-1:0] addr;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } beat_t;

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } arb_state_e;

    // Adds 0..2 dropped beats to the 8-bit drop counter, clamping at 255.
    function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, base} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/switch_fifo.sv
// Synchronous FIFO with a combinational head; push and pop may coincide when full.
module switch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: storage has no reset; emptiness is defined by count_q alone, so
    // stale entries are unreachable and the array maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/switch_merge.sv
// Merges two non-backpressured beat streams through per-port FIFOs into one
// registered output, alternating priority when both ports have data.
module switch_merge
    import switch_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  vld_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic                  vld_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic                  vld_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  ovf_a,
    output logic                  ovf_b,
    output logic [7:0]            drop_cnt
);

    localparam int BW = ADDR_WIDTH + DATA_WIDTH;

    logic [BW-1:0]         head_a, head_b, out_beat_d;
    logic                  full_a, empty_a, full_b, empty_b;
    logic                  pop_a, pop_b, push_a, push_b, drop_a, drop_b;
    arb_state_e            state_q, state_d;
    logic                  vld_q, ovf_a_q, ovf_b_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [7:0]            drop_cnt_q;

    // A full FIFO still accepts a beat when it is popped on the same edge.
    assign push_a = vld_a && (!full_a || pop_a);
    assign push_b = vld_b && (!full_b || pop_b);
    assign drop_a = vld_a && !push_a;
    assign drop_b = vld_b && !push_b;

    switch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(BW)) u_fifo_a (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push_a),
        .pop_i   (pop_a),
        .wdata_i ({addr_a, data_a}),
        .rdata_o (head_a),
        .full_o  (full_a),
        .empty_o (empty_a)
    );

    switch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(BW)) u_fifo_b (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push_b),
        .pop_i   (pop_b),
        .wdata_i ({addr_b, data_b}),
        .rdata_o (head_b),
        .full_o  (full_b),
        .empty_o (empty_b)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pop_a   = 1'b0;
        pop_b   = 1'b0;
        state_d = state_q;
        if (!empty_a && !empty_b) begin
            if (state_q == PRI_A) pop_a = 1'b1;
            else                  pop_b = 1'b1;
        end else if (!empty_a) begin
            pop_a = 1'b1;
        end else if (!empty_b) begin
            pop_b = 1'b1;
        end
        if (pop_a)      state_d = PRI_B;
        else if (pop_b) state_d = PRI_A;
    end

    assign out_beat_d = pop_a ? head_a : (pop_b ? head_b : '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= PRI_A;
            vld_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            ovf_a_q    <= 1'b0;
            ovf_b_q    <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q          <= state_d;
            vld_q            <= pop_a || pop_b;
            {addr_q, data_q} <= out_beat_d;
            ovf_a_q          <= ovf_a_q || drop_a;
            ovf_b_q          <= ovf_b_q || drop_b;
            drop_cnt_q       <= sat_add8(drop_cnt_q, {1'b0, drop_a} + {1'b0, drop_b});
        end
    end

    assign vld_o    = vld_q;
    assign addr_o   = addr_q;
    assign data_o   = data_q;
    assign ovf_a    = ovf_a_q;
    assign ovf_b    = ovf_b_q;
    assign drop_cnt = drop_cnt_q;

endmodule
